// File: rtl/btn_led_ctrl.sv
// N-channel button-to-LED controller: per-channel synchroniser, debouncer and
// press detector feeding a registered LED bank (direct/toggle/counter/lamp test).
module btn_led_ctrl #(
    parameter int N_CH       = 4,
    parameter int DEB_CYCLES = 120000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn,
    input  logic [1:0]      mode,
    output logic [N_CH-1:0] led,
    output logic [N_CH-1:0] press
);

    localparam int            CW       = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    localparam logic [1:0] MODE_DIRECT  = 2'b00;
    localparam logic [1:0] MODE_TOGGLE  = 2'b01;
    localparam logic [1:0] MODE_COUNTER = 2'b10;

    logic [N_CH-1:0] sync1_q;
    logic [N_CH-1:0] sync_q;
    logic [N_CH-1:0] stable_q;
    logic [N_CH-1:0] stable_d;
    logic [CW-1:0]   cnt_q [N_CH];
    logic [CW-1:0]   cnt_d [N_CH];
    logic [N_CH-1:0] press_q;
    logic [N_CH-1:0] press_d;
    logic [N_CH-1:0] tog_q;
    logic [N_CH-1:0] tog_d;
    logic [N_CH-1:0] cnt_val_q;
    logic [N_CH-1:0] cnt_val_d;
    logic [N_CH-1:0] led_q;
    logic [N_CH-1:0] led_d;

    // Two-flop synchroniser; sync1_q is deliberately left without any fan-out logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync_q  <= '0;
        end else begin
            sync1_q <= btn;
            sync_q  <= sync1_q;
        end
    end

    // A bounce back to the stable level drops the count to zero.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = '0;
            if (sync_q[i] != stable_q[i]) begin
                if (cnt_q[i] == DEB_LAST) begin
                    stable_d[i] = sync_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign press_d = stable_d & ~stable_q;
    assign tog_d   = tog_q ^ press_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_q <= '0;
            press_q  <= '0;
            tog_q    <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            press_q  <= press_d;
            tog_q    <= tog_d;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Counter needs three buttons (up, down, clear); narrower banks keep it at zero.
    if (N_CH >= 3) begin : g_counter
        always_comb begin
            cnt_val_d = cnt_val_q;
            if (press_q[2]) begin
                cnt_val_d = '0;
            end else if (press_q[0] ^ press_q[1]) begin
                cnt_val_d = press_q[0] ? cnt_val_q + N_CH'(1) : cnt_val_q - N_CH'(1);
            end
        end
    end else begin : g_no_counter
        assign cnt_val_d = '0;
    end

    always_comb begin
        case (mode)
            MODE_DIRECT:  led_d = stable_q;
            MODE_TOGGLE:  led_d = tog_q;
            MODE_COUNTER: led_d = cnt_val_q;
            default:      led_d = '1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_val_q <= '0;
            led_q     <= '0;
        end else begin
            cnt_val_q <= cnt_val_d;
            led_q     <= led_d;
        end
    end

    assign led   = led_q;
    assign press = press_q;

endmodule

// File: doc/btn_led_ctrl.md
Name: btn_led_ctrl

Overview:
Parametrised button-to-LED controller for the board I/O demo designs, generalising the direct button-to-LED mapping to N channels. Each button input is synchronised, debounced and edge-detected; the LED bank is then driven in one of four selectable modes (direct, toggle, up/down counter, lamp test). The block sits between the raw button pins and the LED pins of the top level.

Parameters:
N_CH, 4, number of button/LED channels; N_CH >= 3 is required for counter mode.
DEB_CYCLES, 120000, consecutive stable-mismatch cycles needed to accept a new button level; minimum 1. Set to 4 in simulation.

Ports:
clk    input   1      system clock
rst    input   1      asynchronous reset, active-high
btn    input   N_CH   raw button levels, asynchronous, 1 = pressed
mode   input   2      00 direct, 01 toggle, 10 counter, 11 lamp test
led    output  N_CH   registered LED drive, 1 = on
press  output  N_CH   one-cycle pulse per accepted press (debounced rising edge)

Behaviour:
- Reset (async, rst=1): sync FFs, stable levels, debounce counters, toggle state, counter, led and press all forced to 0. Release is taken on the next clk edge; no output glitches during reset.
- Sync: two-FF synchroniser per channel (sync1, sync_q). No logic on sync1.
- Debounce, per channel, at each edge:
  - sync_q == stable: cnt <= 0.
  - sync_q != stable and cnt == DEB_CYCLES-1: stable <= sync_q, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - Counter width is clog2(DEB_CYCLES+1). Any bounce back to the stable level restarts the count.
- Debounce latency: a level held from edge e0 reaches stable at edge e0+DEB_CYCLES+1.
- press[i]: registered; set to 1 at the same edge where stable[i] goes 0->1; cleared at the next edge. Releases produce no pulse.
- Toggle state tog[i]: inverted on each press[i]=1 cycle, in every mode, so it is always tracked.
- Counter cnt_val (N_CH bits): updated on press pulses in every mode.
  - press[2]=1: clear to 0. Clear wins over all other inputs.
  - Else press[0] and press[1] both 1: no change.
  - Else press[0]=1: +1, wrapping from all-ones to 0.
  - Else press[1]=1: -1, wrapping from 0 to all-ones.
- led register, updated at every edge from the current register values:
  - mode 00: led <= stable.
  - mode 01: led <= tog.
  - mode 10: led <= cnt_val.
  - mode 11: led <= all ones.
- Latency:
  - A mode change shows on led after 1 edge.
  - A button press appears on led in mode 00 at edge e0+DEB_CYCLES+2.
  - In modes 01/10, led reflects the press one edge after the press pulse.
- Mode switches do not clear tog or cnt_val.
- Reset mid-debounce discards partial counts; after release, a button held throughout needs the full latency again and then generates press.

Test Plan:
- Reset/idle: rst=1 with btn=4'b1111 held -> led=0 and press=0 throughout; after release with mode=00 and DEB_CYCLES=4 -> press=4'b1111 for exactly one cycle at edge 6 after release; led=4'b1111 from the following edge.
- Direct sweep, mode 00: apply btn 0001, 0010, 0100, 1000, 1111, 0000, each held 20 cycles -> led follows each value with a 7-edge lag; one press pulse per newly set bit; none on release.
- Bounce rejection: btn[0] toggled every 2 cycles for 30 cycles, then held 1 -> no press during bouncing; exactly one press[0] pulse after the final hold; led[0] stays 0 until then.
- Toggle, mode 01: three separate presses of btn[3] -> led[3] goes 1, 0, 1; other bits stay 0; switch to mode 00 and back -> led[3]=1 retained.
- Counter, mode 10:
  - Five btn0 presses -> led=4'b0101.
  - btn1 press at 0 -> 4'b1111 (wrap).
  - btn0 and btn1 pressed together -> unchanged.
  - btn2 pressed together with btn0 -> 4'b0000.
- Lamp test and async reset: mode=11 -> led=4'b1111 after 1 edge. Assert rst between clock edges mid-debounce -> led=0 immediately, without waiting for a clock edge.
